// File: rtl/br_exec_pipe_pkg.sv
// Shared CPU packages used by the branch execution pipe.
//   cpu_params : global datapath / index widths
//   uop_types  : branch opcode enum, branch-RS issue uop, branch resolution
package cpu_params;
   localparam int XLEN       = 32;
   localparam int ROB_IDX_W  = 5;
   localparam int PRF_IDX_W  = 6;
   localparam int ARCH_IDX_W = 5;
endpackage

package uop_types;
   import cpu_params::*;

   // 4-bit field leaves room for undefined encodings, which resolve as
   // not-taken branches with no register writeback.
   typedef enum logic [3:0] {
      BR_BEQ  = 4'd0,
      BR_BNE  = 4'd1,
      BR_BLT  = 4'd2,
      BR_BGE  = 4'd3,
      BR_BLTU = 4'd4,
      BR_BGEU = 4'd5,
      BR_JAL  = 4'd6,
      BR_JALR = 4'd7
   } br_op_e;

   typedef struct packed {
      logic [ROB_IDX_W-1:0]  rob_id;
      logic [PRF_IDX_W-1:0]  rd_phy;
      logic [ARCH_IDX_W-1:0] rd_arch;
      br_op_e                fu_opcode;
      logic [XLEN-1:0]       imm;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       rs1_value;
      logic [XLEN-1:0]       rs2_value;
      logic                  predict_taken;
      logic [XLEN-1:0]       predict_target;
   } fu_br_reg_t;

   typedef struct packed {
      logic            taken;
      logic            miss;
      logic [XLEN-1:0] next_pc;
      logic            rd_we;
      logic [XLEN-1:0] rd_value;
   } br_resolve_t;
endpackage

// File: rtl/br_exec_pipe_if.sv
// Branch pipe bus: issue handshake from the branch RS, CDB writeback
// request/grant, and branch resolution broadcast.
//   master : branch RS / CDB arbiter / ROB side
//   slave  : br_exec_pipe
interface br_exec_pipe_if;
   import cpu_params::*;
   import uop_types::*;

   logic                  in_valid;
   logic                  in_ready;
   fu_br_reg_t            in_uop;

   logic                  cdb_valid;
   logic                  cdb_grant;
   logic [ROB_IDX_W-1:0]  cdb_rob_id;
   logic [PRF_IDX_W-1:0]  cdb_rd_phy;
   logic [ARCH_IDX_W-1:0] cdb_rd_arch;
   logic                  cdb_rd_we;
   logic [XLEN-1:0]       cdb_rd_value;

   logic                  br_cdb_valid;
   logic [ROB_IDX_W-1:0]  br_cdb_rob_id;
   logic                  br_cdb_taken;
   logic                  br_cdb_miss;
   logic [XLEN-1:0]       br_cdb_target;

   modport master (
      output in_valid, in_uop, cdb_grant,
      input  in_ready, cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_arch,
             cdb_rd_we, cdb_rd_value, br_cdb_valid, br_cdb_rob_id,
             br_cdb_taken, br_cdb_miss, br_cdb_target
   );

   modport slave (
      input  in_valid, in_uop, cdb_grant,
      output in_ready, cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_arch,
             cdb_rd_we, cdb_rd_value, br_cdb_valid, br_cdb_rob_id,
             br_cdb_taken, br_cdb_miss, br_cdb_target
   );
endinterface

// File: rtl/br_exec_pipe_compare.sv
// br_compare_unit: combinational branch resolution.
//   in : opcode, pc, imm, rs1/rs2 values, rd_arch, prediction
//   out: br_resolve_t (taken, mispredict, next_pc, link writeback)
module br_compare_unit
   import cpu_params::*;
   import uop_types::*;
(
   input  br_op_e                op,
   input  logic [XLEN-1:0]       pc,
   input  logic [XLEN-1:0]       imm,
   input  logic [XLEN-1:0]       rs1,
   input  logic [XLEN-1:0]       rs2,
   input  logic [ARCH_IDX_W-1:0] rd_arch,
   input  logic                  predict_taken,
   input  logic [XLEN-1:0]       predict_target,
   output br_resolve_t           res
);
   logic            eq, lt, ltu, taken, is_jump;
   logic [XLEN-1:0] pc_plus4, jalr_sum, target;

   assign eq       = (rs1 == rs2);
   assign lt       = ($signed(rs1) < $signed(rs2));
   assign ltu      = (rs1 < rs2);
   assign pc_plus4 = pc + XLEN'(4);
   assign jalr_sum = rs1 + imm;
   assign is_jump  = (op == BR_JAL) || (op == BR_JALR);
   assign target   = (op == BR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc + imm;

   always_comb begin
      taken = 1'b0;
      case (op)
         BR_BEQ:  taken = eq;
         BR_BNE:  taken = !eq;
         BR_BLT:  taken = lt;
         BR_BGE:  taken = !lt;
         BR_BLTU: taken = ltu;
         BR_BGEU: taken = !ltu;
         BR_JAL,
         BR_JALR: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      res.taken    = taken;
      res.next_pc  = taken ? target : pc_plus4;
      // target only matters for the mispredict check when actually taken
      res.miss     = (taken != predict_taken) || (taken && (target != predict_target));
      res.rd_we    = is_jump && (rd_arch != '0);
      res.rd_value = res.rd_we ? pc_plus4 : '0;
   end
endmodule

// File: rtl/br_exec_pipe.sv
// br_exec_pipe: two-stage branch execution unit.
//   S1 captures the issued uop and resolves it through br_compare_unit;
//   S2 holds the result and requests the CDB until granted.
//   clk   : rising-edge clock
//   rst   : async active-low reset of valid state
//   flush : squash both stages on the next edge
//   bus   : issue / CDB / branch resolution (slave side)
module br_exec_pipe
   import uop_types::*;
#(
   parameter int XLEN      = cpu_params::XLEN,
   parameter int ROB_IDX_W = cpu_params::ROB_IDX_W,
   parameter int PRF_IDX_W = cpu_params::PRF_IDX_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   br_exec_pipe_if.slave  bus
);
   logic                 s1_valid, s2_valid;
   logic                 s1_advance, accept;
   fu_br_reg_t           s1_uop;
   br_resolve_t          s1_res, s2_res;
   logic [ROB_IDX_W-1:0] s2_rob_id;
   logic [PRF_IDX_W-1:0] s2_rd_phy;
   logic [4:0]           s2_rd_arch;

   assign s1_advance   = !s2_valid || bus.cdb_grant;
   assign bus.in_ready = !s1_valid || s1_advance;
   assign accept       = bus.in_valid && bus.in_ready && !flush;

   br_compare_unit u_cmp (
      .op             (s1_uop.fu_opcode),
      .pc             (s1_uop.pc),
      .imm            (s1_uop.imm),
      .rs1            (s1_uop.rs1_value),
      .rs2            (s1_uop.rs2_value),
      .rd_arch        (s1_uop.rd_arch),
      .predict_taken  (s1_uop.predict_taken),
      .predict_target (s1_uop.predict_target),
      .res            (s1_res)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s1_advance) s2_valid <= s1_valid;
         if (accept)          s1_valid <= 1'b1;
         else if (s1_advance) s1_valid <= 1'b0;
      end
   end

   // payload only moves with its valid; no reset needed
   always_ff @(posedge clk) begin
      if (accept) s1_uop <= bus.in_uop;
      if (s1_valid && s1_advance) begin
         s2_res     <= s1_res;
         s2_rob_id  <= s1_uop.rob_id;
         s2_rd_phy  <= s1_uop.rd_phy;
         s2_rd_arch <= s1_uop.rd_arch;
      end
   end

   assign bus.cdb_valid     = s2_valid;
   assign bus.cdb_rob_id    = s2_rob_id;
   assign bus.cdb_rd_phy    = s2_rd_phy;
   assign bus.cdb_rd_arch   = s2_rd_arch;
   assign bus.cdb_rd_we     = s2_valid && s2_res.rd_we;
   assign bus.cdb_rd_value  = s2_res.rd_value;
   // resolution fires only on the grant cycle; a same-cycle flush kills it
   assign bus.br_cdb_valid  = s2_valid && bus.cdb_grant && !flush;
   assign bus.br_cdb_rob_id = s2_rob_id;
   assign bus.br_cdb_taken  = s2_res.taken;
   assign bus.br_cdb_miss   = s2_valid && s2_res.miss;
   assign bus.br_cdb_target = s2_res.next_pc;
endmodule

// File: tb/tb_br_exec_pipe.sv
module tb_br_exec_pipe;
   import uop_types::*;

   logic clk, rst, flush;
   int   n_chk = 0, n_err = 0;

   br_exec_pipe_if bus();

   br_exec_pipe dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic fu_br_reg_t mk(br_op_e op, logic [31:0] pc, logic [31:0] imm,
                                     logic [31:0] rs1, logic [31:0] rs2, logic pt,
                                     logic [31:0] ptgt, logic [4:0] rd, logic [4:0] rob);
      fu_br_reg_t u;
      u.rob_id = rob; u.rd_phy = {1'b1, rd}; u.rd_arch = rd; u.fu_opcode = op;
      u.imm = imm; u.pc = pc; u.rs1_value = rs1; u.rs2_value = rs2;
      u.predict_taken = pt; u.predict_target = ptgt;
      return u;
   endfunction

   // entered at posedge+1 with grant high; leaves at posedge+1
   task automatic run_op(input string tag, input fu_br_reg_t u, input logic e_tk,
                         input logic e_miss, input logic [31:0] e_tgt,
                         input logic e_we, input logic [31:0] e_val);
      bus.in_uop = u; bus.in_valid = 1'b1;
      @(posedge clk); #1; bus.in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1"}, bus.cdb_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_cdbv"}, bus.cdb_valid, 1);
      chk({tag, "_brv"}, bus.br_cdb_valid, 1);
      chk({tag, "_rob"}, bus.br_cdb_rob_id, u.rob_id);
      chk({tag, "_cdbrob"}, bus.cdb_rob_id, u.rob_id);
      chk({tag, "_phy"}, bus.cdb_rd_phy, u.rd_phy);
      chk({tag, "_taken"}, bus.br_cdb_taken, e_tk);
      chk({tag, "_miss"}, bus.br_cdb_miss, e_miss);
      chk({tag, "_tgt"}, bus.br_cdb_target, e_tgt);
      chk({tag, "_we"}, bus.cdb_rd_we, e_we);
      chk({tag, "_val"}, bus.cdb_rd_value, e_val);
      @(posedge clk); #1;
   endtask

   initial begin
      fu_br_reg_t ua, ub, uc;
      rst = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.cdb_grant = 1'b1;
      bus.in_uop = mk(BR_BEQ, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_cdbv", bus.cdb_valid, 0);
      chk("rst_brv", bus.br_cdb_valid, 0);
      chk("rst_miss", bus.br_cdb_miss, 0);
      chk("rst_we", bus.cdb_rd_we, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_rdy", bus.in_ready, 1);
      @(posedge clk); #1;

      // directed resolution vectors
      run_op("beq", mk(BR_BEQ, 32'h100, 32'h20, 5, 5, 0, 0, 3, 1),
             1, 1, 32'h120, 0, 0);
      run_op("jalr", mk(BR_JALR, 32'h200, 4, 32'h1003, 0, 1, 32'h1006, 1, 2),
             1, 0, 32'h1006, 1, 32'h204);
      run_op("blt", mk(BR_BLT, 32'h300, 32'h40, 32'hFFFF_FFFF, 1, 1, 32'h340, 0, 3),
             1, 0, 32'h340, 0, 0);
      run_op("bltu", mk(BR_BLTU, 32'h300, 32'h40, 32'hFFFF_FFFF, 1, 0, 0, 0, 4),
             0, 0, 32'h304, 0, 0);
      run_op("bge", mk(BR_BGE, 32'h300, 32'h40, 32'hFFFF_FFFF, 1, 1, 32'h340, 0, 5),
             0, 1, 32'h304, 0, 0);
      run_op("bgeu", mk(BR_BGEU, 32'h700, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 1, 32'h6F0, 0, 6),
             1, 0, 32'h6F0, 0, 0);
      run_op("bne", mk(BR_BNE, 32'h800, 32'h8, 3, 3, 0, 0, 0, 7),
             0, 0, 32'h804, 0, 0);
      run_op("jal0", mk(BR_JAL, 32'h400, 32'h10, 0, 0, 1, 32'h500, 0, 8),
             1, 1, 32'h410, 0, 0);
      run_op("unk", mk(br_op_e'(4'hF), 32'h600, 32'h10, 0, 0, 1, 32'h610, 9, 9),
             0, 1, 32'h604, 0, 0);

      // back-to-back ops against a stalled CDB
      ua = mk(BR_JAL, 32'h1000, 32'h8, 0, 0, 1, 32'h1008, 2, 10);
      ub = mk(BR_BEQ, 32'h2000, 32'h8, 1, 2, 0, 0, 0, 11);
      uc = mk(BR_BNE, 32'h3000, 32'h8, 1, 2, 1, 32'h3008, 0, 12);
      bus.cdb_grant = 1'b0;
      bus.in_uop = ua; bus.in_valid = 1'b1;
      @(posedge clk); #1; bus.in_uop = ub;
      @(posedge clk); #1; bus.in_uop = uc;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_rdy", bus.in_ready, 0);
         chk("stall_cdbv", bus.cdb_valid, 1);
         chk("stall_brv", bus.br_cdb_valid, 0);
         chk("stall_rob", bus.cdb_rob_id, 10);
         chk("stall_tgt", bus.br_cdb_target, 32'h1008);
         chk("stall_val", bus.cdb_rd_value, 32'h1004);
         @(posedge clk); #1;
      end
      bus.cdb_grant = 1'b1;
      @(negedge clk);
      chk("ord_a_brv", bus.br_cdb_valid, 1);
      chk("ord_a_rob", bus.br_cdb_rob_id, 10);
      chk("ord_a_rdy", bus.in_ready, 1);
      @(posedge clk); #1; bus.in_valid = 1'b0;
      @(negedge clk);
      chk("ord_b_brv", bus.br_cdb_valid, 1);
      chk("ord_b_rob", bus.br_cdb_rob_id, 11);
      chk("ord_b_tgt", bus.br_cdb_target, 32'h2004);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ord_c_brv", bus.br_cdb_valid, 1);
      chk("ord_c_rob", bus.br_cdb_rob_id, 12);
      chk("ord_c_miss", bus.br_cdb_miss, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ord_empty", bus.cdb_valid, 0);
      @(posedge clk); #1;

      // flush with both stages full and a new op offered
      bus.cdb_grant = 1'b0;
      bus.in_uop = ua; bus.in_valid = 1'b1;
      @(posedge clk); #1; bus.in_uop = ub;
      @(posedge clk); #1; bus.in_uop = uc;
      flush = 1'b1; bus.cdb_grant = 1'b1;
      @(negedge clk);
      chk("fl_full", bus.cdb_valid, 1);
      chk("fl_brv_kill", bus.br_cdb_valid, 0);
      @(posedge clk); #1; flush = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      chk("fl_cdbv", bus.cdb_valid, 0);
      chk("fl_brv", bus.br_cdb_valid, 0);
      chk("fl_rdy", bus.in_ready, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("fl_cdbv2", bus.cdb_valid, 0);
      @(posedge clk); #1;

      // reset while S2 waits on the grant
      bus.cdb_grant = 1'b0;
      bus.in_uop = ua; bus.in_valid = 1'b1;
      @(posedge clk); #1; bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rw_wait", bus.cdb_valid, 1);
      #1 rst = 1'b0;
      #1 chk("rw_async", bus.cdb_valid, 0);
      chk("rw_we", bus.cdb_rd_we, 0);
      @(negedge clk); rst = 1'b1; bus.cdb_grant = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rw_after", bus.cdb_valid, 0);
         chk("rw_brv", bus.br_cdb_valid, 0);
      end
      chk("rw_rdy", bus.in_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/br_exec_pipe.md
BR_EXEC_PIPE -- requirements
Module: br_exec_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter ROB_IDX_W, default 5, ROB id width.
REQ-003 SHALL have parameter PRF_IDX_W, default 6, physical register index width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  in  1  synchronous squash of all in-flight ops.
REQ-007 SHALL have port in_valid / in_ready  in/out  1/1  issue handshake from branch RS.
REQ-008 SHALL have port in_uop  in  fu_br_reg_t  rob_id, rd_phy, rd_arch, fu_opcode, imm, pc, rs1_value, rs2_value, predict_taken, predict_target.
REQ-009 SHALL have port cdb_valid / cdb_grant  out/in  1/1  CDB request and arbiter grant.
REQ-010 SHALL have port cdb_rob_id, cdb_rd_phy, cdb_rd_arch, cdb_rd_we, cdb_rd_value  out  ROB_IDX_W, PRF_IDX_W, 5, 1, XLEN  writeback payload.
REQ-011 SHALL have port br_cdb_valid, br_cdb_rob_id, br_cdb_taken, br_cdb_miss, br_cdb_target  out  1, ROB_IDX_W, 1, 1, XLEN  branch resolution.

Function
REQ-012 SHALL accept an op when in_valid && in_ready; in_ready = !s1_valid || s1_advance.
REQ-013 SHALL use stage S1 (operand capture, compare, adders) and stage S2 (result register); accept-to-cdb_valid latency exactly 2 cycles with no stall.
REQ-014 SHALL advance S1 to S2 when !s2_valid || cdb_grant; S2 holds all outputs stable while cdb_valid && !cdb_grant.
REQ-015 SHALL sustain one op per cycle when cdb_grant is held high.
REQ-016 SHALL decode fu_opcode BEQ, BNE, BLT, BGE (signed), BLTU, BGEU (unsigned), JAL, JALR; JAL/JALR always taken.
REQ-017 SHALL compute taken target pc+imm (branches, JAL), (rs1_value+imm) & ~1 (JALR); next_pc = taken ? target : pc+4; all sums modulo 2^XLEN.
REQ-018 SHALL set br_cdb_target = next_pc and br_cdb_taken = actual taken.
REQ-019 SHALL set br_cdb_miss = (taken != predict_taken) || (taken && target != predict_target).
REQ-020 SHALL set cdb_rd_we = 1 and cdb_rd_value = pc+4 only for JAL/JALR with rd_arch != 0; otherwise cdb_rd_we = 0, value 0.
REQ-021 SHALL assert br_cdb_valid for exactly one cycle per op, on the cycle the op's cdb_grant is received.
REQ-022 SHALL, on flush, clear s1_valid and s2_valid next edge; flush overrides a same-cycle accept and grant, and no br_cdb_valid is produced for squashed ops.
REQ-023 SHALL treat unknown fu_opcode as not-taken branch with rd_we = 0.

Reset
REQ-024 SHALL on rst low clear s1_valid, s2_valid immediately; cdb_valid, br_cdb_valid, br_cdb_miss, cdb_rd_we = 0; in_ready = 1 in the cycle after release.
REQ-025 SHALL reset only valid/control flops; payload flops need no reset.
REQ-026 SHALL discard an op in flight when reset asserts mid-operation; no output follows release.

Structure
REQ-027 SHALL take fu_br_reg_t, branch opcode enum, and XLEN/ROB/PRF widths from the shared cpu_params / uop_types packages; resolution struct br_resolve_t added to uop_types.
REQ-028 SHALL instantiate one sub-module, br_compare_unit (combinational compare + target + mispredict), used in S1.

Verification
REQ-029 SHALL test BEQ pc=0x100, imm=0x20, rs1=rs2=5, predict_taken=0 -> 2 cycles later br_cdb_taken=1, miss=1, target=0x120, cdb_rd_we=0.
REQ-030 SHALL test JALR pc=0x200, rs1=0x1003, imm=4, rd_arch=1, predicted 0x1006 -> target=0x1006, miss=0, cdb_rd_value=0x204, rd_we=1.
REQ-031 SHALL test BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken, target=pc+4.
REQ-032 SHALL test cdb_grant low 3 cycles with 3 back-to-back ops -> in_ready drops after 2 accepted, outputs stable, all 3 emitted in order once grant rises.
REQ-033 SHALL test flush with S1 and S2 full and in_valid high -> no cdb_valid/br_cdb_valid next cycle, in_ready=1.
REQ-034 SHALL test rst asserted while S2 waits for grant -> cdb_valid drops immediately, stays 0 after release.
